// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus receiver.
// Control bit map, FSM encoding, opcode masks, AC helpers.
package lcd_pkg;

  localparam int CTRL_E  = 2;
  localparam int CTRL_RS = 1;
  localparam int CTRL_RW = 0;

  typedef enum logic [1:0] {
    ST_MODE8  = 2'd0,
    ST_HI_NIB = 2'd1,
    ST_LO_NIB = 2'd2
  } lcd_st_e;

  typedef struct packed {
    logic [3:0] nib;
    logic       rs;
  } nib_t;

  localparam logic [7:0] CLEAR_M  = 8'hFF;
  localparam logic [7:0] CLEAR_V  = 8'h01;
  localparam logic [7:0] ENTRY_M  = 8'hFC;
  localparam logic [7:0] ENTRY_V  = 8'h04;
  localparam logic [7:0] FUNC_M   = 8'hE0;
  localparam logic [7:0] FUNC_V   = 8'h20;
  localparam logic [7:0] CGADDR_M = 8'hC0;
  localparam logic [7:0] CGADDR_V = 8'h40;
  localparam logic [7:0] DDADDR_M = 8'h80;
  localparam logic [7:0] DDADDR_V = 8'h80;

  localparam int ENTRY_ID = 1;
  localparam int FUNC_DL  = 4;

  function automatic logic op_hit(
    input logic [7:0] b,
    input logic [7:0] m,
    input logic [7:0] v
  );
    return (b & m) == v;
  endfunction

  // DD RAM address step: two 40-char lines at 0x00 and 0x40
  function automatic logic [6:0] dd_step(
    input logic [6:0] a,
    input logic       inc
  );
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  // CG RAM address step, wraps within 64 bytes
  function automatic logic [6:0] cg_step(
    input logic [6:0] a,
    input logic       inc
  );
    logic [5:0] s;
    s = inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1;
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/lcd_bus_rx_if.sv
// LCD parallel bus: host drives data nibble and E/RS/RW.
// The receiver only listens.
interface lcd_bus_rx_if;
  logic [3:0] lcd_data;
  logic [2:0] lcd_ctrl;

  modport master (
    output lcd_data,
    output lcd_ctrl
  );

  modport slave (
    input lcd_data,
    input lcd_ctrl
  );
endinterface

// File: rtl/lcd_strobe_det.sv
// Input sampling and E strobe qualification.
// Emits a strobe at E fall when E stayed high long enough.
module lcd_strobe_det
  import lcd_pkg::*;
#(
  parameter int MIN_E_HIGH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_i,
  input  logic [2:0] ctrl_i,
  output logic       stb_o,
  output nib_t       nib_o
);

  localparam int CW = $clog2(MIN_E_HIGH + 1);
  localparam logic [CW-1:0] CMAX = CW'(MIN_E_HIGH);

  logic [3:0]    d1_data_q;
  logic [3:0]    d2_data_q;
  logic [2:0]    d1_ctrl_q;
  logic [2:0]    d2_ctrl_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          blk_q;

  // Saturating E-high run length; held at zero while blocked
  always_comb begin
    cnt_d = '0;
    if (!blk_q && d1_ctrl_q[CTRL_E]) begin
      cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Two-deep input pipe, counter, and post-reset E block
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_data_q <= '0;
      d2_data_q <= '0;
      d1_ctrl_q <= '0;
      d2_ctrl_q <= '0;
      cnt_q     <= '0;
      blk_q     <= 1'b1;
    end else begin
      d1_data_q <= data_i;
      d2_data_q <= d1_data_q;
      d1_ctrl_q <= ctrl_i;
      d2_ctrl_q <= d1_ctrl_q;
      cnt_q     <= cnt_d;
      if (!ctrl_i[CTRL_E]) blk_q <= 1'b0;
    end
  end

  assign stb_o = d2_ctrl_q[CTRL_E]
               & ~d1_ctrl_q[CTRL_E]
               & ~d2_ctrl_q[CTRL_RW]
               & (cnt_q >= CMAX);

  assign nib_o.nib = d2_data_q;
  assign nib_o.rs  = d2_ctrl_q[CTRL_RS];

endmodule

// File: rtl/lcd_bus_rx.sv
// HD44780-style bus receiver: nibble pairing,
// instruction decode, address counter and RAM writes.
module lcd_bus_rx
  import lcd_pkg::*;
#(
  parameter int MIN_E_HIGH = 8
) (
  input  logic         clk,
  input  logic         rst,
  lcd_bus_rx_if.slave  bus,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_rs,
  output logic         mode4,
  output logic [6:0]   ac,
  output logic         cg_sel,
  output logic         dd_we,
  output logic [4:0]   dd_addr,
  output logic [7:0]   dd_wdata,
  output logic         cg_we,
  output logic [5:0]   cg_addr,
  output logic [7:0]   cg_wdata,
  output logic         clr_pulse,
  output logic         proto_err
);

  logic    stb;
  nib_t    snib;
  logic [7:0] asm_b;

  lcd_st_e    st_q;
  logic [3:0] hi_q;
  logic       hrs_q;
  logic       inc_q;
  logic       mode4_q;
  logic [6:0] ac_q;
  logic       cg_sel_q;
  logic       bv_q;
  logic [7:0] byte_q;
  logic       brs_q;
  logic       dd_we_q;
  logic [4:0] dd_addr_q;
  logic [7:0] dd_wdata_q;
  logic       cg_we_q;
  logic [5:0] cg_addr_q;
  logic [7:0] cg_wdata_q;
  logic       clr_q;
  logic       perr_q;

  lcd_strobe_det #(
    .MIN_E_HIGH (MIN_E_HIGH)
  ) u_det (
    .clk    (clk),
    .rst    (rst),
    .data_i (bus.lcd_data),
    .ctrl_i (bus.lcd_ctrl),
    .stb_o  (stb),
    .nib_o  (snib)
  );

  assign asm_b = {hi_q, snib.nib};

  // Nibble pairing FSM with decode and AC update
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_MODE8;
      hi_q       <= '0;
      hrs_q      <= 1'b0;
      inc_q      <= 1'b1;
      mode4_q    <= 1'b0;
      ac_q       <= '0;
      cg_sel_q   <= 1'b0;
      bv_q       <= 1'b0;
      byte_q     <= '0;
      brs_q      <= 1'b0;
      dd_we_q    <= 1'b0;
      dd_addr_q  <= '0;
      dd_wdata_q <= '0;
      cg_we_q    <= 1'b0;
      cg_addr_q  <= '0;
      cg_wdata_q <= '0;
      clr_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      bv_q    <= 1'b0;
      dd_we_q <= 1'b0;
      cg_we_q <= 1'b0;
      clr_q   <= 1'b0;
      perr_q  <= 1'b0;
      if (stb) begin
        unique case (st_q)
          ST_MODE8: begin
            if (!snib.rs && snib.nib == 4'h2) begin
              st_q    <= ST_HI_NIB;
              mode4_q <= 1'b1;
            end
          end
          ST_HI_NIB: begin
            hi_q  <= snib.nib;
            hrs_q <= snib.rs;
            st_q  <= ST_LO_NIB;
          end
          ST_LO_NIB: begin
            if (snib.rs != hrs_q) begin
              perr_q <= 1'b1;
              hi_q   <= snib.nib;
              hrs_q  <= snib.rs;
            end else begin
              bv_q   <= 1'b1;
              byte_q <= asm_b;
              brs_q  <= snib.rs;
              st_q   <= ST_HI_NIB;
              if (!snib.rs) begin
                unique case (1'b1)
                  op_hit(asm_b, CLEAR_M, CLEAR_V): begin
                    ac_q     <= '0;
                    cg_sel_q <= 1'b0;
                    inc_q    <= 1'b1;
                    clr_q    <= 1'b1;
                  end
                  op_hit(asm_b, ENTRY_M, ENTRY_V): begin
                    inc_q <= asm_b[ENTRY_ID];
                  end
                  op_hit(asm_b, FUNC_M, FUNC_V): begin
                    if (asm_b[FUNC_DL]) begin
                      st_q    <= ST_MODE8;
                      mode4_q <= 1'b0;
                    end
                  end
                  op_hit(asm_b, CGADDR_M, CGADDR_V): begin
                    cg_sel_q <= 1'b1;
                    ac_q     <= {1'b0, asm_b[5:0]};
                  end
                  op_hit(asm_b, DDADDR_M, DDADDR_V): begin
                    cg_sel_q <= 1'b0;
                    ac_q     <= asm_b[6:0];
                  end
                  default: ;
                endcase
              end else if (cg_sel_q) begin
                cg_we_q    <= 1'b1;
                cg_addr_q  <= ac_q[5:0];
                cg_wdata_q <= asm_b;
                ac_q       <= cg_step(ac_q, inc_q);
              end else begin
                if (ac_q[6:4] == 3'b000) begin
                  dd_we_q    <= 1'b1;
                  dd_addr_q  <= {1'b0, ac_q[3:0]};
                  dd_wdata_q <= asm_b;
                end else if (ac_q[6:4] == 3'b100) begin
                  dd_we_q    <= 1'b1;
                  dd_addr_q  <= {1'b1, ac_q[3:0]};
                  dd_wdata_q <= asm_b;
                end
                ac_q <= dd_step(ac_q, inc_q);
              end
            end
          end
          default: st_q <= ST_MODE8;
        endcase
      end
    end
  end

  assign byte_valid = bv_q;
  assign byte_out   = byte_q;
  assign byte_rs    = brs_q;
  assign mode4      = mode4_q;
  assign ac         = ac_q;
  assign cg_sel     = cg_sel_q;
  assign dd_we      = dd_we_q;
  assign dd_addr    = dd_addr_q;
  assign dd_wdata   = dd_wdata_q;
  assign cg_we      = cg_we_q;
  assign cg_addr    = cg_addr_q;
  assign cg_wdata   = cg_wdata_q;
  assign clr_pulse  = clr_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: byte vector table
// plus hand sequences for glitch, protocol and reset cases.
module tb_lcd_bus_rx;

  logic       clk;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       byte_rs;
  logic       mode4;
  logic [6:0] ac;
  logic       cg_sel;
  logic       dd_we;
  logic [4:0] dd_addr;
  logic [7:0] dd_wdata;
  logic       cg_we;
  logic [5:0] cg_addr;
  logic [7:0] cg_wdata;
  logic       clr_pulse;
  logic       proto_err;

  int checks;
  int failures;
  int bv_cnt;

  lcd_bus_rx_if bus();

  lcd_bus_rx #(
    .MIN_E_HIGH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .byte_rs    (byte_rs),
    .mode4      (mode4),
    .ac         (ac),
    .cg_sel     (cg_sel),
    .dd_we      (dd_we),
    .dd_addr    (dd_addr),
    .dd_wdata   (dd_wdata),
    .cg_we      (cg_we),
    .cg_addr    (cg_addr),
    .cg_wdata   (cg_wdata),
    .clr_pulse  (clr_pulse),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
  end

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic       dwe;
    logic [4:0] da;
    logic       cwe;
    logic [5:0] ca;
    logic [6:0] eac;
    logic       ecs;
    logic       eclr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic add(input logic rs, input logic [7:0] b,
                     input logic dwe, input logic [4:0] da,
                     input logic cwe, input logic [5:0] ca,
                     input logic [6:0] eac, input logic ecs,
                     input logic eclr);
    vec_t v;
    v.rs = rs; v.b = b;
    v.dwe = dwe; v.da = da;
    v.cwe = cwe; v.ca = ca;
    v.eac = eac; v.ecs = ecs; v.eclr = eclr;
    vq.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge where the
  // registered result of the strobe is visible.
  task automatic nib(input logic rs, input logic [3:0] d,
                     input int hi, input logic rw);
    bus.lcd_data = d;
    bus.lcd_ctrl = {1'b1, rs, rw};
    repeat (hi) @(posedge clk);
    @(negedge clk);
    bus.lcd_ctrl = {1'b0, rs, rw};
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    nib(rs, b[7:4], 12, 1'b0);
    nib(rs, b[3:0], 12, 1'b0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] cgpat [8];
  int n0;

  initial begin
    checks   = 0;
    failures = 0;
    bv_cnt   = 0;
    rst      = 1'b1;
    bus.lcd_data = 4'h0;
    bus.lcd_ctrl = 3'b000;
    cgpat = '{8'h0C, 8'h0E, 8'h04, 8'h1F,
              8'h04, 8'h0A, 8'h1B, 8'h00};

    add(0, 8'h80, 0, 0, 0, 0, 7'h00, 0, 0);
    add(1, 8'h41, 1, 0, 0, 0, 7'h01, 0, 0);
    add(0, 8'hC0, 0, 0, 0, 0, 7'h40, 0, 0);
    for (int i = 0; i < 16; i++)
      add(1, 8'h30 + 8'(i), 1, 5'(16 + i), 0, 0,
          7'h41 + 7'(i), 0, 0);
    add(1, 8'h55, 0, 0, 0, 0, 7'h51, 0, 0);
    add(0, 8'hA7, 0, 0, 0, 0, 7'h27, 0, 0);
    add(1, 8'h33, 0, 0, 0, 0, 7'h40, 0, 0);
    add(0, 8'h04, 0, 0, 0, 0, 7'h40, 0, 0);
    add(1, 8'h61, 1, 5'd16, 0, 0, 7'h27, 0, 0);
    add(0, 8'h80, 0, 0, 0, 0, 7'h00, 0, 0);
    add(1, 8'h62, 1, 5'd0, 0, 0, 7'h67, 0, 0);
    add(1, 8'h63, 0, 0, 0, 0, 7'h66, 0, 0);
    add(0, 8'h06, 0, 0, 0, 0, 7'h66, 0, 0);
    add(0, 8'hE7, 0, 0, 0, 0, 7'h67, 0, 0);
    add(1, 8'h64, 0, 0, 0, 0, 7'h00, 0, 0);
    add(0, 8'h40, 0, 0, 0, 0, 7'h00, 1, 0);
    for (int i = 0; i < 8; i++)
      add(1, cgpat[i], 0, 0, 1, 6'(i),
          7'(i + 1), 1, 0);
    add(0, 8'h7F, 0, 0, 0, 0, 7'h3F, 1, 0);
    add(1, 8'hAA, 0, 0, 1, 6'd63, 7'h00, 1, 0);
    add(0, 8'h04, 0, 0, 0, 0, 7'h00, 1, 0);
    add(1, 8'hBB, 0, 0, 1, 6'd0, 7'h3F, 1, 0);
    add(0, 8'h01, 0, 0, 0, 0, 7'h00, 0, 1);
    add(1, 8'hCC, 1, 5'd0, 0, 0, 7'h01, 0, 0);
    add(0, 8'h0C, 0, 0, 0, 0, 7'h01, 0, 0);
    add(0, 8'h28, 0, 0, 0, 0, 7'h01, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_mode4", 32'(mode4), 0);
    chk("rst_ac", 32'(ac), 0);
    chk("rst_cg_sel", 32'(cg_sel), 0);
    chk("rst_bv", 32'(byte_valid), 0);
    chk("rst_byte", 32'(byte_out), 0);
    chk("rst_dd_we", 32'(dd_we), 0);
    chk("rst_dd_addr", 32'(dd_addr), 0);
    chk("rst_cg_addr", 32'(cg_addr), 0);

    nib(0, 4'h3, 12, 0);
    nib(0, 4'h3, 12, 0);
    nib(0, 4'h3, 12, 0);
    chk("init_mode4_pre", 32'(mode4), 0);
    nib(0, 4'h2, 12, 0);
    chk("init_mode4", 32'(mode4), 1);
    @(negedge clk);
    chk("init_no_bv", 32'(bv_cnt), 0);

    foreach (vq[i]) begin
      send_byte(vq[i].rs, vq[i].b);
      chk($sformatf("v%0d_bv", i), 32'(byte_valid), 1);
      chk($sformatf("v%0d_byte", i), 32'(byte_out),
          32'(vq[i].b));
      chk($sformatf("v%0d_rs", i), 32'(byte_rs),
          32'(vq[i].rs));
      chk($sformatf("v%0d_dd_we", i), 32'(dd_we),
          32'(vq[i].dwe));
      chk($sformatf("v%0d_cg_we", i), 32'(cg_we),
          32'(vq[i].cwe));
      chk($sformatf("v%0d_ac", i), 32'(ac),
          32'(vq[i].eac));
      chk($sformatf("v%0d_cg_sel", i), 32'(cg_sel),
          32'(vq[i].ecs));
      chk($sformatf("v%0d_clr", i), 32'(clr_pulse),
          32'(vq[i].eclr));
      chk($sformatf("v%0d_mode4", i), 32'(mode4), 1);
      if (vq[i].dwe) begin
        chk($sformatf("v%0d_dd_addr", i), 32'(dd_addr),
            32'(vq[i].da));
        chk($sformatf("v%0d_dd_wdata", i), 32'(dd_wdata),
            32'(vq[i].b));
      end
      if (vq[i].cwe) begin
        chk($sformatf("v%0d_cg_addr", i), 32'(cg_addr),
            32'(vq[i].ca));
        chk($sformatf("v%0d_cg_wdata", i), 32'(cg_wdata),
            32'(vq[i].b));
      end
    end

    @(negedge clk);
    n0 = bv_cnt;
    nib(1, 4'h5, 3, 0);
    nib(1, 4'h6, 7, 0);
    nib(0, 4'h8, 12, 1);
    @(negedge clk);
    chk("glitch_no_bv", 32'(bv_cnt), 32'(n0));
    send_byte(0, 8'h80);
    chk("glitch_byte", 32'(byte_out), 32'h80);
    chk("glitch_ac", 32'(ac), 0);
    nib(1, 4'h4, 8, 0);
    nib(1, 4'h2, 8, 0);
    chk("min_bv", 32'(byte_valid), 1);
    chk("min_byte", 32'(byte_out), 32'h42);
    chk("min_dd_addr", 32'(dd_addr), 0);
    chk("min_ac", 32'(ac), 1);

    nib(0, 4'h8, 12, 0);
    nib(1, 4'h4, 12, 0);
    chk("perr_pulse", 32'(proto_err), 1);
    chk("perr_no_bv", 32'(byte_valid), 0);
    nib(1, 4'h1, 12, 0);
    chk("perr_bv", 32'(byte_valid), 1);
    chk("perr_byte", 32'(byte_out), 32'h41);
    chk("perr_rs", 32'(byte_rs), 1);
    chk("perr_dd_addr", 32'(dd_addr), 1);
    chk("perr_ac", 32'(ac), 2);

    send_byte(0, 8'h30);
    chk("func8_mode4", 32'(mode4), 0);
    nib(0, 4'h2, 12, 0);
    chk("func4_mode4", 32'(mode4), 1);

    nib(0, 4'h8, 12, 0);
    pulse_rst();
    chk("midrst_mode4", 32'(mode4), 0);
    chk("midrst_ac", 32'(ac), 0);
    chk("midrst_byte", 32'(byte_out), 0);

    bus.lcd_data = 4'h2;
    bus.lcd_ctrl = 3'b100;
    repeat (12) @(posedge clk);
    @(negedge clk);
    pulse_rst();
    repeat (12) @(posedge clk);
    @(negedge clk);
    bus.lcd_ctrl = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("estrobe_rst_mode4", 32'(mode4), 0);

    nib(0, 4'h2, 12, 0);
    chk("rearm_mode4", 32'(mode4), 1);
    send_byte(0, 8'hC5);
    chk("rearm_byte", 32'(byte_out), 32'hC5);
    chk("rearm_ac", 32'(ac), 32'h45);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
